// File: rtl/pong_game_fsm_if.sv
// Signal bundle between the pong game FSM and the surrounding game logic.
// The master drives ball/paddle positions and the start button; the slave is the FSM.
interface pong_game_fsm_if;
  logic       start;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [9:0] pad_l_y;
  logic [9:0] pad_r_y;
  logic       game_running;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic [1:0] winner;
  logic       serve_dir;
  logic [2:0] state;

  modport master (
    output start, ball_x, ball_y, pad_l_y, pad_r_y,
    input  game_running, score_l, score_r, winner, serve_dir, state
  );

  modport slave (
    input  start, ball_x, ball_y, pad_l_y, pad_r_y,
    output game_running, score_l, score_r, winner, serve_dir, state
  );
endinterface

// File: rtl/pong_game_fsm.sv
// Pong match sequencer: idle, serve pause, rally with miss detection and scoring,
// post-point pause and game-over hold. All outputs come straight from registers.
module pong_game_fsm #(
  parameter int unsigned SCREEN_W     = 640,
  parameter int unsigned PADDLE_H     = 64,
  parameter int unsigned BALL_H       = 16,
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned PAUSE_CYCLES = 25000000
) (
  input  logic           clk_in,
  input  logic           reset,
  pong_game_fsm_if.slave bus_io
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StServe = 3'd1,
    StPlay  = 3'd2,
    StPoint = 3'd3,
    StOver  = 3'd4
  } state_e;

  localparam logic [9:0]  RightX    = 10'(SCREEN_W - 1);
  localparam logic [10:0] BallH     = 11'(BALL_H);
  localparam logic [10:0] PaddleH   = 11'(PADDLE_H);
  localparam logic [24:0] PauseLast = 25'(PAUSE_CYCLES - 1);
  localparam logic [3:0]  WinScore  = 4'(WIN_SCORE);

  state_e      state_q;
  logic        start_q;
  logic [24:0] pause_q;
  logic        run_q;
  logic [3:0]  score_l_q;
  logic [3:0]  score_r_q;
  logic [1:0]  winner_q;
  logic        dir_q;

  logic        start_edge;
  logic        hit_l;
  logic        hit_r;
  logic        miss_l;
  logic        miss_r;
  logic        pause_done;
  logic [3:0]  score_l_inc;
  logic [3:0]  score_r_inc;

  // Overlap is evaluated at 11 bits so ball/paddle bottoms near 1023 do not wrap.
  always_comb begin
    start_edge  = bus_io.start & ~start_q;
    hit_l       = (({1'b0, bus_io.ball_y} + BallH) > {1'b0, bus_io.pad_l_y}) &&
                  ({1'b0, bus_io.ball_y} < ({1'b0, bus_io.pad_l_y} + PaddleH));
    hit_r       = (({1'b0, bus_io.ball_y} + BallH) > {1'b0, bus_io.pad_r_y}) &&
                  ({1'b0, bus_io.ball_y} < ({1'b0, bus_io.pad_r_y} + PaddleH));
    miss_l      = (bus_io.ball_x == 10'd0) && !hit_l;
    miss_r      = (bus_io.ball_x == RightX) && !hit_r;
    pause_done  = (pause_q == PauseLast);
    score_l_inc = score_l_q + 4'd1;
    score_r_inc = score_r_q + 4'd1;
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      start_q   <= 1'b0;
      pause_q   <= '0;
      run_q     <= 1'b0;
      score_l_q <= '0;
      score_r_q <= '0;
      winner_q  <= 2'b00;
      dir_q     <= 1'b0;
    end else begin
      start_q <= bus_io.start;
      case (state_q)
        StIdle: begin
          run_q     <= 1'b0;
          score_l_q <= '0;
          score_r_q <= '0;
          winner_q  <= 2'b00;
          dir_q     <= 1'b0;
          pause_q   <= '0;
          if (start_edge) state_q <= StServe;
        end
        StServe: begin
          if (pause_done) begin
            state_q <= StPlay;
            pause_q <= '0;
            run_q   <= 1'b1;
          end else begin
            pause_q <= pause_q + 25'd1;
          end
        end
        StPlay: begin
          // A simultaneous left/right miss is scored as a left miss only.
          if (miss_l) begin
            score_r_q <= score_r_inc;
            dir_q     <= 1'b0;
            run_q     <= 1'b0;
            pause_q   <= '0;
            if (score_r_inc == WinScore) begin
              state_q  <= StOver;
              winner_q <= 2'b10;
            end else begin
              state_q <= StPoint;
            end
          end else if (miss_r) begin
            score_l_q <= score_l_inc;
            dir_q     <= 1'b1;
            run_q     <= 1'b0;
            pause_q   <= '0;
            if (score_l_inc == WinScore) begin
              state_q  <= StOver;
              winner_q <= 2'b01;
            end else begin
              state_q <= StPoint;
            end
          end
        end
        StPoint: begin
          if (pause_done) begin
            state_q <= StServe;
            pause_q <= '0;
          end else begin
            pause_q <= pause_q + 25'd1;
          end
        end
        StOver: begin
          run_q <= 1'b0;
          if (start_edge) begin
            score_l_q <= '0;
            score_r_q <= '0;
            winner_q  <= 2'b00;
            dir_q     <= 1'b0;
            pause_q   <= '0;
            state_q   <= StServe;
          end
        end
        default: begin
          state_q <= StIdle;
          run_q   <= 1'b0;
          pause_q <= '0;
        end
      endcase
    end
  end

  assign bus_io.state        = state_q;
  assign bus_io.game_running = run_q;
  assign bus_io.score_l      = score_l_q;
  assign bus_io.score_r      = score_r_q;
  assign bus_io.winner       = winner_q;
  assign bus_io.serve_dir    = dir_q;

endmodule

// File: tb/tb_pong_game_fsm.sv
// Self-checking bench for pong_game_fsm: boundary table, directed match sequences and
// randomized play compared every cycle against a rule-level reference model.
module tb_pong_game_fsm;

  localparam int Sw    = 640;
  localparam int PadH  = 64;
  localparam int BallH = 16;
  localparam int Win   = 2;
  localparam int Pause = 4;

  logic clk_in;
  logic reset;

  pong_game_fsm_if bus ();
  pong_game_fsm_if bus2 ();

  // Second instance with a 1-pixel playfield so left and right misses coincide.
  assign bus2.start   = bus.start;
  assign bus2.ball_x  = bus.ball_x;
  assign bus2.ball_y  = bus.ball_y;
  assign bus2.pad_l_y = bus.pad_l_y;
  assign bus2.pad_r_y = bus.pad_r_y;

  pong_game_fsm #(
    .SCREEN_W    (Sw),
    .PADDLE_H    (PadH),
    .BALL_H      (BallH),
    .WIN_SCORE   (Win),
    .PAUSE_CYCLES(Pause)
  ) u_dut (
    .clk_in(clk_in),
    .reset (reset),
    .bus_io(bus)
  );

  pong_game_fsm #(
    .SCREEN_W    (1),
    .PADDLE_H    (PadH),
    .BALL_H      (BallH),
    .WIN_SCORE   (Win),
    .PAUSE_CYCLES(Pause)
  ) u_dut2 (
    .clk_in(clk_in),
    .reset (reset),
    .bus_io(bus2)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  // Reference model: state code, scores, winner, serve direction, run flag, pause cycles left.
  int m_st, m_sl, m_sr, m_win, m_dir, m_run, m_left;
  int m_prev;

  typedef struct {
    int bx, by, pl, pr;
    int exp_sl, exp_sr, exp_st;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int covers(input int by, input int py);
    return ((by + BallH > py) && (by < py + PadH)) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_st = 0; m_sl = 0; m_sr = 0; m_win = 0; m_dir = 0; m_run = 0; m_left = 0; m_prev = 0;
  endtask

  task automatic model_update();
    int st_edge, bx, by, lm, rm;
    st_edge = (bus.start == 1'b1 && m_prev == 0) ? 1 : 0;
    bx = int'(bus.ball_x);
    by = int'(bus.ball_y);
    lm = (bx == 0 && covers(by, int'(bus.pad_l_y)) == 0) ? 1 : 0;
    rm = (bx == Sw - 1 && covers(by, int'(bus.pad_r_y)) == 0) ? 1 : 0;
    case (m_st)
      0: if (st_edge != 0) begin m_st = 1; m_left = Pause; end
      1: begin
        if (m_left == 1) begin m_st = 2; m_run = 1; end
        else m_left--;
      end
      2: begin
        if (lm != 0) begin
          m_sr++; m_dir = 0; m_run = 0;
          if (m_sr == Win) begin m_st = 4; m_win = 2; end
          else begin m_st = 3; m_left = Pause; end
        end else if (rm != 0) begin
          m_sl++; m_dir = 1; m_run = 0;
          if (m_sl == Win) begin m_st = 4; m_win = 1; end
          else begin m_st = 3; m_left = Pause; end
        end
      end
      3: begin
        if (m_left == 1) begin m_st = 1; m_left = Pause; end
        else m_left--;
      end
      4: if (st_edge != 0) begin
        m_sl = 0; m_sr = 0; m_win = 0; m_dir = 0; m_st = 1; m_left = Pause;
      end
      default: m_st = 0;
    endcase
    m_prev = bus.start ? 1 : 0;
  endtask

  task automatic compare_all();
    check("state", int'(bus.state), m_st);
    check("game_running", int'(bus.game_running), m_run);
    check("score_l", int'(bus.score_l), m_sl);
    check("score_r", int'(bus.score_r), m_sr);
    check("winner", int'(bus.winner), m_win);
    check("serve_dir", int'(bus.serve_dir), m_dir);
  endtask

  task automatic step();
    model_update();
    @(posedge clk_in);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    model_reset();
    compare_all();
    #1;
    reset = 1'b1;
  endtask

  task automatic idle_inputs();
    bus.ball_x  = 10'd320;
    bus.ball_y  = 10'd100;
    bus.pad_l_y = 10'd300;
    bus.pad_r_y = 10'd300;
  endtask

  task automatic start_pulse();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_play();
    int n;
    n = 0;
    while (m_st != 2 && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (m_st != 2) begin
      errors++;
      $display("FAIL wait_play timeout state %0d required 2", int'(bus.state));
    end
  endtask

  task automatic count_state(input int st, output int n);
    n = 0;
    while (int'(bus.state) == st && n < 20) begin
      n++;
      step();
    end
  endtask

  task automatic set_pos(input int bx, input int by, input int pl, input int pr);
    bus.ball_x  = 10'(bx);
    bus.ball_y  = 10'(by);
    bus.pad_l_y = 10'(pl);
    bus.pad_r_y = 10'(pr);
  endtask

  initial begin
    int n;
    vecs[0]  = '{0,   100,  300,  300, 0, 1, 3};
    vecs[1]  = '{0,   100,  90,   300, 0, 0, 2};
    vecs[2]  = '{0,   100,  116,  300, 0, 1, 3};
    vecs[3]  = '{0,   100,  115,  300, 0, 0, 2};
    vecs[4]  = '{0,   100,  36,   300, 0, 1, 3};
    vecs[5]  = '{0,   100,  37,   300, 0, 0, 2};
    vecs[6]  = '{639, 100,  300,  300, 1, 0, 3};
    vecs[7]  = '{639, 100,  300,  90,  0, 0, 2};
    vecs[8]  = '{0,   1015, 1000, 300, 0, 0, 2};
    vecs[9]  = '{639, 1015, 300,  1000, 0, 0, 2};
    vecs[10] = '{320, 100,  300,  300, 0, 0, 2};
    vecs[11] = '{638, 100,  300,  300, 0, 0, 2};
    vecs[12] = '{639, 100,  300,  116, 1, 0, 3};

    reset = 1'b1;
    bus.start = 1'b0;
    idle_inputs();
    model_reset();
    #1;
    do_reset();

    // Boundary table: each vector applied on the first PLAY cycle of a fresh game.
    for (int i = 0; i < 13; i++) begin
      do_reset();
      idle_inputs();
      start_pulse();
      wait_play();
      set_pos(vecs[i].bx, vecs[i].by, vecs[i].pl, vecs[i].pr);
      step();
      check($sformatf("vec%0d_score_l", i), int'(bus.score_l), vecs[i].exp_sl);
      check($sformatf("vec%0d_score_r", i), int'(bus.score_r), vecs[i].exp_sr);
      check($sformatf("vec%0d_state", i), int'(bus.state), vecs[i].exp_st);
      idle_inputs();
    end

    // Serve timing, left miss, hit, and a right-player win.
    do_reset();
    idle_inputs();
    start_pulse();
    check("serve_entry", int'(bus.state), 1);
    count_state(1, n);
    check("serve_len", n, 4);
    check("play_state", int'(bus.state), 2);
    check("play_running", int'(bus.game_running), 1);
    set_pos(0, 100, 300, 300);
    step();
    check("lmiss_score_r", int'(bus.score_r), 1);
    check("lmiss_dir", int'(bus.serve_dir), 0);
    check("lmiss_state", int'(bus.state), 3);
    idle_inputs();
    count_state(3, n);
    check("point_len", n, 4);
    check("point_to_serve", int'(bus.state), 1);
    wait_play();
    set_pos(0, 100, 90, 300);
    step();
    check("hit_state", int'(bus.state), 2);
    check("hit_score_r", int'(bus.score_r), 1);
    set_pos(639, 100, 300, 300);
    step();
    check("rmiss1_score_l", int'(bus.score_l), 1);
    check("rmiss1_dir", int'(bus.serve_dir), 1);
    idle_inputs();
    wait_play();
    set_pos(639, 100, 300, 300);
    bus.start = 1'b1;
    step();
    check("rmiss2_score_l", int'(bus.score_l), 2);
    check("rmiss2_winner", int'(bus.winner), 1);
    check("rmiss2_state", int'(bus.state), 4);
    idle_inputs();
    repeat (5) step();
    check("over_hold_state", int'(bus.state), 4);
    check("over_hold_score", int'(bus.score_l), 2);
    bus.start = 1'b0;
    step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("restart_state", int'(bus.state), 1);
    check("restart_score_l", int'(bus.score_l), 0);
    check("restart_winner", int'(bus.winner), 0);
    check("restart_dir", int'(bus.serve_dir), 0);

    // Simultaneous left and right miss on the 1-pixel instance.
    do_reset();
    idle_inputs();
    start_pulse();
    wait_play();
    set_pos(0, 100, 300, 300);
    step();
    check("both_miss_score_r", int'(bus2.score_r), 1);
    check("both_miss_score_l", int'(bus2.score_l), 0);
    check("both_miss_state", int'(bus2.state), 3);
    idle_inputs();

    // Reset mid-SERVE, then IDLE must hold without a new start edge.
    do_reset();
    start_pulse();
    step();
    check("pre_reset_state", int'(bus.state), 1);
    do_reset();
    check("mid_serve_reset_state", int'(bus.state), 0);
    repeat (3) step();
    check("post_reset_idle", int'(bus.state), 0);

    // Randomized play against the model, with occasional asynchronous resets.
    for (int c = 0; c < 3000; c++) begin
      int r;
      if ($urandom_range(0, 399) == 0) do_reset();
      bus.start = ($urandom_range(0, 7) == 0);
      r = $urandom_range(0, 3);
      bus.ball_x = (r == 0) ? 10'd0 : (r == 1) ? 10'd639 : 10'($urandom_range(0, 639));
      bus.ball_y  = 10'($urandom_range(0, 1023));
      bus.pad_l_y = 10'($urandom_range(0, 1023));
      bus.pad_r_y = 10'($urandom_range(0, 1023));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
